// File: rtl/lc3_io_pkg.sv
// Shared definitions for the LC-3 memory-mapped I/O controllers.
package lc3_io_pkg;

   typedef enum logic [2:0] {
      ST_INIT    = 3'd0,
      ST_IDLE    = 3'd1,
      ST_LOAD    = 3'd2,
      ST_SET_RDY = 3'd3,
      ST_WAIT_RD = 3'd4,
      ST_CLEAR   = 3'd5
   } kbd_state_t;

   localparam logic [15:0] KBSR_ADDR  = 16'hFE00;
   localparam logic [15:0] KBDR_ADDR  = 16'hFE02;
   localparam logic [15:0] KBSR_READY = 16'h8000;
   localparam logic [15:0] KBSR_IDLE  = 16'h0000;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with synchronous active-high reset. Pointers carry one
// extra MSB so full and empty can be told apart. A push into a full FIFO is
// accepted only when a pop happens in the same cycle (the pop frees the slot
// first); otherwise it is rejected and flagged on push_drop.
module sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic             clk_sys,
   input  logic             rst,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] pop_data,
   output logic             full,
   output logic             empty,
   output logic             push_drop
);

   localparam int AW = $clog2(DEPTH);

   logic [AW:0]      wr_ptr;
   logic [AW:0]      rd_ptr;
   logic [WIDTH-1:0] mem [DEPTH];
   logic             do_push;
   logic             do_pop;

   assign empty     = (wr_ptr == rd_ptr);
   assign full      = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign do_pop    = pop && !empty;
   assign do_push   = push && (!full || do_pop);
   assign push_drop = push && !do_push;
   assign pop_data  = mem[rd_ptr[AW-1:0]];

   // Pointer update; reset flushes the buffer.
   always_ff @(posedge clk_sys) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      end
   end

   // Storage write; when full with a simultaneous pop this overwrites the
   // slot being read out this cycle, which is safe since the read is combinational.
   always_ff @(posedge clk_sys) begin
      if (!rst && do_push) mem[wr_ptr[AW-1:0]] <= push_data;
   end

endmodule

// File: rtl/kbd_rx_ctrl.sv
// Keyboard receive controller: buffers UART bytes and presents them one at a
// time to the LC-3 KBDR/KBSR external load ports, waiting for the CPU to read
// KBDR before clearing ready and presenting the next byte.
//
//  state      | meaning
//  -----------+------------------------------------------------------------
//  ST_INIT    | first cycle after reset, load KBSR with x0000
//  ST_IDLE    | nothing to present, wait for a byte
//  ST_LOAD    | pop FIFO head into the KBDR value register
//  ST_SET_RDY | load KBDR with the byte and KBSR with ready in one cycle
//  ST_WAIT_RD | byte presented, wait for the CPU read of KBDR
//  ST_CLEAR   | load KBSR with x0000, then present next byte or idle
module kbd_rx_ctrl
   import lc3_io_pkg::*;
#(
   parameter int FIFO_DEPTH = 4
) (
   input  logic        i_Clk,
   input  logic        i_Reset,
   input  logic        i_Rx_DV,
   input  logic [7:0]  i_Rx_Byte,
   input  logic        i_KBDR_Read,
   output logic        LD_KBDR_EXT,
   output logic        LD_KBSR_EXT,
   output logic [15:0] kbdr_ext_out,
   output logic [15:0] kbsr_ext_out,
   output logic [7:0]  o_Drop_Count
);

   kbd_state_t state;
   kbd_state_t state_nxt;
   logic [7:0] fifo_head;
   logic       fifo_full;
   logic       fifo_empty;
   logic       fifo_drop;
   logic       fifo_pop;
   logic       have_data;
   logic       ld_kbdr;
   logic       ld_kbsr;

   assign fifo_pop = (state == ST_LOAD);

   // A byte arriving this cycle is in the FIFO by the time LOAD pops, so it
   // counts as available; this gives LOAD the cycle right after i_Rx_DV.
   assign have_data = !fifo_empty || i_Rx_DV;

   sync_fifo #(
      .WIDTH (8),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk_sys   (i_Clk),
      .rst       (i_Reset),
      .push      (i_Rx_DV),
      .push_data (i_Rx_Byte),
      .pop       (fifo_pop),
      .pop_data  (fifo_head),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .push_drop (fifo_drop)
   );

   // State register.
   always_ff @(posedge i_Clk) begin
      if (i_Reset) state <= ST_INIT;
      else         state <= state_nxt;
   end

   // Next-state and Moore load decode.
   always_comb begin
      state_nxt    = state;
      ld_kbdr      = 1'b0;
      ld_kbsr      = 1'b0;
      kbsr_ext_out = KBSR_IDLE;
      case (state)
         ST_INIT: begin
            ld_kbsr   = 1'b1;
            state_nxt = ST_IDLE;
         end
         ST_IDLE: begin
            if (have_data) state_nxt = ST_LOAD;
         end
         ST_LOAD: begin
            state_nxt = ST_SET_RDY;
         end
         ST_SET_RDY: begin
            ld_kbdr      = 1'b1;
            ld_kbsr      = 1'b1;
            kbsr_ext_out = KBSR_READY;
            state_nxt    = ST_WAIT_RD;
         end
         ST_WAIT_RD: begin
            if (i_KBDR_Read) state_nxt = ST_CLEAR;
         end
         ST_CLEAR: begin
            ld_kbsr   = 1'b1;
            state_nxt = have_data ? ST_LOAD : ST_IDLE;
         end
         default: begin
            state_nxt = ST_INIT;
         end
      endcase
   end

   // Loads are suppressed while reset is held so the datapath sees nothing
   // until the INIT cycle that follows reset release.
   assign LD_KBDR_EXT = ld_kbdr && !i_Reset;
   assign LD_KBSR_EXT = ld_kbsr && !i_Reset;

   // KBDR value register, captured from the FIFO head on the LOAD pop.
   always_ff @(posedge i_Clk) begin
      if (i_Reset)               kbdr_ext_out <= 16'h0000;
      else if (state == ST_LOAD) kbdr_ext_out <= {8'h00, fifo_head};
   end

   // Saturating count of bytes rejected by a full FIFO.
   always_ff @(posedge i_Clk) begin
      if (i_Reset)                            o_Drop_Count <= 8'h00;
      else if (fifo_drop && (o_Drop_Count != 8'hFF)) o_Drop_Count <= o_Drop_Count + 8'h01;
   end

   logic unused_full;
   assign unused_full = fifo_full;

endmodule

// File: tb/tb_kbd_rx_ctrl.sv
// Bench for kbd_rx_ctrl: directed scenarios plus random traffic, all checked
// cycle by cycle against a transaction-level model (byte queue, drop counter
// and the event times at which bytes are taken, shown and cleared).
module tb_kbd_rx_ctrl;

   localparam int DEPTH = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic        dv;
   logic [7:0]  rx_byte;
   logic        rd;
   logic        ld_kbdr;
   logic        ld_kbsr;
   logic [15:0] kbdr_out;
   logic [15:0] kbsr_out;
   logic [7:0]  drop_cnt;

   always #5 clk = ~clk;

   kbd_rx_ctrl #(.FIFO_DEPTH(DEPTH)) dut (
      .i_Clk        (clk),
      .i_Reset      (rst),
      .i_Rx_DV      (dv),
      .i_Rx_Byte    (rx_byte),
      .i_KBDR_Read  (rd),
      .LD_KBDR_EXT  (ld_kbdr),
      .LD_KBSR_EXT  (ld_kbsr),
      .kbdr_ext_out (kbdr_out),
      .kbsr_ext_out (kbsr_out),
      .o_Drop_Count (drop_cnt)
   );

   int n_chk  = 0;
   int n_pass = 0;
   int cyc    = 0;

   // Reference model state.
   logic [7:0] q[$];
   logic [7:0] kbdr_m;
   int         drops;
   int         pop_at, present_at, clear_at, init_at;
   bit         free, waiting, prev_rst;

   task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
   endtask

   // One clock cycle: drive inputs, compare outputs to the model, advance model.
   task automatic step(input bit s_dv, input logic [7:0] s_byte, input bit s_rd, input bit s_rst);
      bit pres, have, pop_now;
      rst = s_rst; dv = s_dv; rx_byte = s_byte; rd = s_rd;
      #1;
      pres = (cyc == present_at);
      if (s_rst) begin
         chk("ld_kbdr_in_reset", 16'(ld_kbdr), 16'h0);
         chk("ld_kbsr_in_reset", 16'(ld_kbsr), 16'h0);
         if (prev_rst) begin
            chk("kbdr_reset", kbdr_out, 16'h0000);
            chk("kbsr_reset", kbsr_out, 16'h0000);
            chk("drop_reset", 16'(drop_cnt), 16'h0);
         end
      end else begin
         chk("ld_kbdr", 16'(ld_kbdr), 16'(pres));
         chk("ld_kbsr", 16'(ld_kbsr), 16'(pres || cyc == clear_at || cyc == init_at));
         chk("kbsr", kbsr_out, pres ? 16'h8000 : 16'h0000);
         if (pres) chk("kbdr", kbdr_out, {8'h00, kbdr_m});
         chk("drop_count", 16'(drop_cnt), 16'(drops));
      end

      if (s_rst) begin
         q.delete();
         drops = 0; kbdr_m = 8'h00; free = 0; waiting = 0;
         pop_at = -1; present_at = -1; clear_at = -1; init_at = cyc + 1;
      end else begin
         have    = (q.size() > 0) || s_dv;
         pop_now = (cyc == pop_at);
         if (pop_now) begin
            kbdr_m     = q.pop_front();
            present_at = cyc + 1;
         end
         if (s_dv) begin
            if (q.size() < DEPTH) q.push_back(s_byte);
            else if (drops < 255) drops++;
         end
         if (waiting && s_rd) begin
            waiting  = 0;
            clear_at = cyc + 1;
         end
         if (pres) waiting = 1;
         if (free || cyc == clear_at) begin
            if (have) begin
               pop_at = cyc + 1;
               free   = 0;
            end else begin
               free = 1;
            end
         end
         if (cyc == init_at) free = 1;
      end
      prev_rst = s_rst;
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic idle_n(input int n);
      for (int i = 0; i < n; i++) step(0, 8'h00, 0, 0);
   endtask

   task automatic read_when_ready();
      for (int i = 0; i < 60; i++) begin
         if (waiting) begin
            step(0, 8'h00, 1, 0);
            return;
         end
         step(0, 8'h00, 0, 0);
      end
      n_chk++;
      $display("FAIL ready_timeout: no byte presented within 60 cycles (cycle %0d)", cyc);
   endtask

   initial begin
      rst = 1'b1; dv = 1'b0; rx_byte = 8'h00; rd = 1'b0;
      pop_at = -1; present_at = -1; clear_at = -1; init_at = -1;
      drops = 0; kbdr_m = 8'h00; free = 0; waiting = 0; prev_rst = 0;

      // Power-on reset, two cycles.
      step(0, 8'h00, 0, 1);
      step(0, 8'h00, 0, 1);
      idle_n(3);

      // Single byte and its read.
      step(1, 8'h41, 0, 0);
      idle_n(5);
      read_when_ready();
      idle_n(4);

      // Three bytes back-to-back, reads spaced out.
      step(1, 8'h31, 0, 0);
      step(1, 8'h32, 0, 0);
      step(1, 8'h33, 0, 0);
      for (int k = 0; k < 3; k++) begin
         idle_n(10);
         read_when_ready();
      end
      idle_n(5);

      // Overflow: six bytes, no reads, one dropped.
      for (int k = 0; k < 6; k++) step(1, 8'hA0 + 8'(k), 0, 0);
      idle_n(4);
      read_when_ready();
      // Push exactly in the LOAD cycle that pops from a full FIFO.
      for (int i = 0; i < 10; i++) begin
         if (cyc == pop_at) begin
            step(1, 8'hB7, 0, 0);
            break;
         end
         step(0, 8'h00, 0, 0);
      end
      for (int k = 0; k < 5; k++) begin
         idle_n(2);
         read_when_ready();
      end
      idle_n(4);

      // Spurious reads in IDLE and in SET_RDY.
      step(0, 8'h00, 1, 0);
      step(0, 8'h00, 1, 0);
      step(1, 8'h5A, 0, 0);
      for (int i = 0; i < 6; i++) step(0, 8'h00, (cyc == present_at), 0);
      idle_n(3);
      read_when_ready();
      idle_n(3);

      // Reset while waiting for a read with two bytes buffered.
      step(1, 8'h61, 0, 0);
      step(1, 8'h62, 0, 0);
      step(1, 8'h63, 0, 0);
      idle_n(4);
      step(0, 8'h00, 0, 1);
      step(0, 8'h00, 0, 1);
      idle_n(20);

      // Drop counter saturation.
      for (int k = 0; k < 300; k++) step(1, 8'($urandom), 0, 0);
      idle_n(2);
      step(0, 8'h00, 0, 1);
      step(0, 8'h00, 0, 1);
      idle_n(3);

      // Random traffic.
      for (int k = 0; k < 3000; k++) begin
         step($urandom_range(0, 99) < 40, 8'($urandom), $urandom_range(0, 99) < 15,
              $urandom_range(0, 999) < 4);
      end
      idle_n(10);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
